// File: rtl/wb_stage_buffered.sv
// Writeback stage: result-source select, sub-word load extraction, a small writeback FIFO
// toward the register-file write port, a forwarding lookup over pending writes and a retire counter.
module wb_stage_buffered #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int DEPTH      = 2,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic                              RegW_EN,
    input  logic [ADDR_WIDTH-1:0]             addrD,
    input  logic [1:0]                        src_sel,
    input  logic [DATA_WIDTH-1:0]             alu_result,
    input  logic [DATA_WIDTH-1:0]             loadValue,
    input  logic [1:0]                        ld_size,
    input  logic                              ld_unsigned,
    input  logic [$clog2(DATA_WIDTH/8)-1:0]   ld_offset,
    input  logic [DATA_WIDTH-1:0]             link_pc,
    input  logic [DATA_WIDTH-1:0]             csr_value,
    output logic                              rf_we,
    output logic [ADDR_WIDTH-1:0]             rf_addr,
    output logic [DATA_WIDTH-1:0]             rf_data,
    input  logic                              rf_ready,
    input  logic [ADDR_WIDTH-1:0]             hz_addr,
    output logic                              hz_hit,
    output logic [DATA_WIDTH-1:0]             hz_data,
    output logic [CNT_WIDTH-1:0]              retire_cnt
);
    localparam int OFF_W = $clog2(DATA_WIDTH/8);
    localparam int SH_W  = OFF_W + 3;
    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = $clog2(DEPTH+1);

    logic [ADDR_WIDTH-1:0] addrMem_reg [DEPTH];
    logic [DATA_WIDTH-1:0] dataMem_reg [DEPTH];
    logic [PTR_W-1:0]      rdPtr_reg, wrPtr_reg, rdPtr_next, wrPtr_next;
    logic [OCC_W-1:0]      count_reg, count_next, remaining;
    logic                  rfWe_reg, rfWe_next;
    logic [ADDR_WIDTH-1:0] rfAddr_reg, rfAddr_next;
    logic [DATA_WIDTH-1:0] rfData_reg, rfData_next;
    logic [CNT_WIDTH-1:0]  retireCnt_reg;

    logic accept, push, pop;
    logic [1:0]            effSize;
    logic [SH_W-1:0]       byteShift, laneShift;
    logic [DATA_WIDTH-1:0] lane, laneMask, loadExt, selData;
    logic                  signBit;

    assign in_ready = (count_reg != OCC_W'(DEPTH));
    assign accept   = in_valid && in_ready;
    assign push     = accept && RegW_EN && (addrD != '0);
    assign pop      = rfWe_reg && rf_ready;

    // Coarser accesses clear the offset bits below their own alignment, so
    // misaligned offsets silently round down to the containing lane.
    assign effSize   = (ld_size == 2'b11 && DATA_WIDTH == 32) ? 2'b10 : ld_size;
    assign byteShift = {ld_offset, 3'b000};

    always_comb begin
        laneShift = byteShift;
        laneMask  = DATA_WIDTH'(8'hFF);
        case (effSize)
            2'b00: laneShift = byteShift;
            2'b01: laneShift = byteShift & ~SH_W'(8);
            2'b10: laneShift = byteShift & ~SH_W'(24);
            default: laneShift = '0;
        endcase
        lane = loadValue >> laneShift;
        case (effSize)
            2'b00: begin laneMask = DATA_WIDTH'(8'hFF);         signBit = lane[7];  end
            2'b01: begin laneMask = DATA_WIDTH'(16'hFFFF);      signBit = lane[15]; end
            2'b10: begin laneMask = DATA_WIDTH'(32'hFFFF_FFFF); signBit = lane[31]; end
            default: begin laneMask = '1;                       signBit = lane[DATA_WIDTH-1]; end
        endcase
        loadExt = (lane & laneMask) | ((!ld_unsigned && signBit) ? ~laneMask : '0);
    end

    always_comb begin
        case (src_sel)
            2'b00:   selData = alu_result;
            2'b01:   selData = loadExt;
            2'b10:   selData = link_pc;
            default: selData = csr_value;
        endcase
    end

    always_comb begin
        count_next = count_reg;
        case ({push, pop})
            2'b10:   count_next = count_reg + OCC_W'(1);
            2'b01:   count_next = count_reg - OCC_W'(1);
            default: count_next = count_reg;
        endcase
        rdPtr_next = pop  ? rdPtr_reg + PTR_W'(1) : rdPtr_reg;
        wrPtr_next = push ? wrPtr_reg + PTR_W'(1) : wrPtr_reg;
        remaining  = count_reg - OCC_W'(pop);
        // The head output is registered, so pick what the head will be after this edge.
        if (count_next == '0) begin
            rfWe_next   = 1'b0;
            rfAddr_next = '0;
            rfData_next = '0;
        end else if (remaining == '0) begin
            rfWe_next   = 1'b1;
            rfAddr_next = addrD;
            rfData_next = selData;
        end else begin
            rfWe_next   = 1'b1;
            rfAddr_next = addrMem_reg[rdPtr_next];
            rfData_next = dataMem_reg[rdPtr_next];
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            addrMem_reg[wrPtr_reg] <= addrD;
            dataMem_reg[wrPtr_reg] <= selData;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rdPtr_reg     <= '0;
            wrPtr_reg     <= '0;
            count_reg     <= '0;
            rfWe_reg      <= 1'b0;
            rfAddr_reg    <= '0;
            rfData_reg    <= '0;
            retireCnt_reg <= '0;
        end else begin
            rdPtr_reg  <= rdPtr_next;
            wrPtr_reg  <= wrPtr_next;
            count_reg  <= count_next;
            rfWe_reg   <= rfWe_next;
            rfAddr_reg <= rfAddr_next;
            rfData_reg <= rfData_next;
            if (accept) retireCnt_reg <= retireCnt_reg + CNT_WIDTH'(1);
        end
    end

    assign rf_we      = rfWe_reg;
    assign rf_addr    = rfAddr_reg;
    assign rf_data    = rfData_reg;
    assign retire_cnt = retireCnt_reg;

    // matchVec is indexed by age: entry gi is the gi-th oldest pending write.
    logic [DEPTH-1:0]      matchVec;
    logic [DATA_WIDTH-1:0] matchData [DEPTH];

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_hz
            logic [PTR_W-1:0] idx;
            assign idx           = rdPtr_reg + PTR_W'(gi);
            assign matchVec[gi]  = (OCC_W'(gi) < count_reg) && (addrMem_reg[idx] == hz_addr)
                                   && (hz_addr != '0);
            assign matchData[gi] = dataMem_reg[idx];
        end
    endgenerate

    always_comb begin
        hz_hit  = |matchVec;
        hz_data = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (matchVec[k]) hz_data = matchData[k];
        end
    end
endmodule
